// File: rtl/pipe_stage_reg.sv
// Purpose : one pipeline-stage register (payload + control) with valid/ready
//           handshake, optional one-entry skid buffer, bubble masking, flush
//           and a saturating stall counter.
// Latency : 1 cycle from accepted input to out_valid when the stage is empty.
// Backpr. : SKID=1 -> o_in_ready is a flop, low only while two entries are held;
//           SKID=0 -> o_in_ready = !out_valid | i_out_ready (combinational).
//
// Ports:
//   i_clk, i_rst_n            clock (rising edge), async active-low reset
//   i_in_valid / o_in_ready   upstream handshake
//   i_in_data / i_in_ctrl     incoming payload / control vector
//   i_in_bubble               zero KILL_MASK bits of the accepted control
//   i_flush                   synchronous discard of all held entries
//   o_out_valid / i_out_ready downstream handshake
//   o_out_data / o_out_ctrl   main entry (ctrl masked while invalid)
//   o_occupancy               entries held, 0..2
//   o_stall_cnt               saturating count of out_valid & !out_ready cycles
module pipe_stage_reg #(
   parameter int unsigned       DATA_W    = 64,
   parameter int unsigned       CTRL_W    = 16,
   parameter logic [CTRL_W-1:0] KILL_MASK = {CTRL_W{1'b1}},
   parameter bit                SKID      = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [DATA_W-1:0] i_in_data,
   input  logic [CTRL_W-1:0] i_in_ctrl,
   input  logic              i_in_bubble,
   input  logic              i_flush,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic [CTRL_W-1:0] o_out_ctrl,
   output logic [1:0]        o_occupancy,
   output logic [15:0]       o_stall_cnt
);

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_in_rdy;
   logic [DATA_W-1:0]   r_main_data;
   logic [CTRL_W-1:0]   r_main_ctrl;
   logic [DATA_W-1:0]   r_skid_data;
   logic [CTRL_W-1:0]   r_skid_ctrl;
   logic [15:0]         r_stall_cnt;

   logic                w_out_valid;
   logic                w_in_ready;
   logic                w_in_xfer;
   logic                w_out_xfer;
   logic                w_ld_main_in;
   logic                w_ld_main_skid;
   logic                w_ld_skid;
   logic [CTRL_W-1:0]   w_in_ctrl_m;

   assign w_out_valid = (r_state != S_EMPTY);
   // Skid mode uses a flop so upstream sees no path from out_ready.
   assign w_in_ready  = SKID ? r_in_rdy : (~w_out_valid | i_out_ready);
   assign w_in_xfer   = i_in_valid & w_in_ready;
   assign w_out_xfer  = w_out_valid & i_out_ready;
   assign w_in_ctrl_m = i_in_bubble ? (i_in_ctrl & ~KILL_MASK) : i_in_ctrl;

   always_comb begin
      w_state_nxt    = r_state;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
      if (i_flush) begin
         // Flush wins over any same-cycle accept; a same-cycle delivery
         // has already happened from the downstream point of view.
         w_state_nxt = S_EMPTY;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_in_xfer) begin
                  w_ld_main_in = 1'b1;
                  w_state_nxt  = S_ONE;
               end
            end
            S_ONE: begin
               if (w_in_xfer && w_out_xfer) begin
                  w_ld_main_in = 1'b1;
               end else if (w_in_xfer) begin
                  if (SKID) begin
                     w_ld_skid   = 1'b1;
                     w_state_nxt = S_TWO;
                  end else begin
                     // Unreachable without skid: accept implies out_ready.
                     w_ld_main_in = 1'b1;
                  end
               end else if (w_out_xfer) begin
                  w_state_nxt = S_EMPTY;
               end
            end
            S_TWO: begin
               if (w_out_xfer) begin
                  w_ld_main_skid = 1'b1;
                  w_state_nxt    = S_ONE;
               end
            end
            default: w_state_nxt = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= S_EMPTY;
         r_in_rdy <= 1'b1;
      end else begin
         r_state  <= w_state_nxt;
         r_in_rdy <= (w_state_nxt != S_TWO);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_main_data <= '0;
         r_main_ctrl <= '0;
         r_skid_data <= '0;
         r_skid_ctrl <= '0;
      end else begin
         if (w_ld_main_in) begin
            r_main_data <= i_in_data;
            r_main_ctrl <= w_in_ctrl_m;
         end else if (w_ld_main_skid) begin
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
         end
         if (w_ld_skid) begin
            r_skid_data <= i_in_data;
            r_skid_ctrl <= w_in_ctrl_m;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stall_cnt <= '0;
      end else if (w_out_valid && !i_out_ready && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign o_in_ready  = w_in_ready;
   assign o_out_valid = w_out_valid;
   assign o_out_data  = r_main_data;
   // Empty stage never presents live enables downstream.
   assign o_out_ctrl  = w_out_valid ? r_main_ctrl : (r_main_ctrl & ~KILL_MASK);
   assign o_occupancy = r_state;
   assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

   localparam logic [15:0] KM = 16'h00C0;

   typedef struct packed {
      logic [63:0] d;
      logic [15:0] c;
   } ent_t;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_in_valid;
   logic        o_in_ready;
   logic [63:0] i_in_data;
   logic [15:0] i_in_ctrl;
   logic        i_in_bubble;
   logic        i_flush;
   logic        o_out_valid;
   logic        i_out_ready;
   logic [63:0] o_out_data;
   logic [15:0] o_out_ctrl;
   logic [1:0]  o_occupancy;
   logic [15:0] o_stall_cnt;

   int n_pass  = 0;
   int n_total = 0;
   bit chk_en  = 0;

   pipe_stage_reg #(
      .DATA_W(64), .CTRL_W(16), .KILL_MASK(KM), .SKID(1'b1)
   ) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
      .i_in_data(i_in_data), .i_in_ctrl(i_in_ctrl),
      .i_in_bubble(i_in_bubble), .i_flush(i_flush),
      .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
      .o_out_data(o_out_data), .o_out_ctrl(o_out_ctrl),
      .o_occupancy(o_occupancy), .o_stall_cnt(o_stall_cnt)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Reference model: a FIFO of at most two entries plus the last head seen,
   // which is what the output register shows once the stage empties.
   ent_t        q[$];
   ent_t        m_last;
   logic [15:0] m_stall;

   always @(posedge i_clk or negedge i_rst_n) begin : model
      int   n;
      bit   ixf;
      bit   oxf;
      ent_t e;
      if (!i_rst_n) begin
         q.delete();
         m_last  = '0;
         m_stall = '0;
      end else begin
         n   = q.size();
         ixf = i_in_valid && (n < 2);
         oxf = (n > 0) && i_out_ready;
         if (n > 0 && !i_out_ready && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
         if (i_flush) begin
            q.delete();
         end else begin
            if (oxf) void'(q.pop_front());
            if (ixf) begin
               e.d = i_in_data;
               e.c = i_in_bubble ? (i_in_ctrl & ~KM) : i_in_ctrl;
               q.push_back(e);
            end
         end
         if (q.size() > 0) m_last = q[0];
      end
   end

   always @(negedge i_clk) begin
      if (chk_en) begin
         chk("m_out_valid", {63'd0, o_out_valid}, {63'd0, q.size() > 0});
         chk("m_occupancy", {62'd0, o_occupancy}, 64'(q.size()));
         chk("m_in_ready",  {63'd0, o_in_ready},  {63'd0, q.size() < 2});
         chk("m_out_data",  o_out_data, m_last.d);
         chk("m_out_ctrl",  {48'd0, o_out_ctrl},
             {48'd0, (q.size() > 0) ? m_last.c : (m_last.c & ~KM)});
         chk("m_stall_cnt", {48'd0, o_stall_cnt}, {48'd0, m_stall});
      end
   end

   initial begin
      i_rst_n = 1'b0; i_in_valid = 1'b0; i_in_data = '0; i_in_ctrl = '0;
      i_in_bubble = 1'b0; i_flush = 1'b0; i_out_ready = 1'b0;
      tick(); tick();
      chk("rst_out_valid", {63'd0, o_out_valid}, 64'd0);
      chk("rst_occupancy", {62'd0, o_occupancy}, 64'd0);
      chk("rst_in_ready",  {63'd0, o_in_ready},  64'd1);
      chk("rst_stall",     {48'd0, o_stall_cnt}, 64'd0);
      chk("rst_out_ctrl",  {48'd0, o_out_ctrl},  64'd0);
      i_rst_n = 1'b1;
      chk_en  = 1'b1;

      // Reset mid-stream with two entries held.
      i_in_valid = 1'b1; i_in_data = 64'hA1; i_in_ctrl = 16'h0001; tick();
      i_in_data = 64'hA2; tick();
      i_in_valid = 1'b0;
      chk("pre_rst_occ", {62'd0, o_occupancy}, 64'd2);
      #2 i_rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", {63'd0, o_out_valid}, 64'd0);
      chk("mid_rst_occ",       {62'd0, o_occupancy}, 64'd0);
      chk("mid_rst_in_ready",  {63'd0, o_in_ready},  64'd1);
      chk("mid_rst_stall",     {48'd0, o_stall_cnt}, 64'd0);
      tick(); tick();
      i_rst_n = 1'b1;

      // Fill / drain with three back-to-back inputs.
      i_in_valid = 1'b1; i_in_ctrl = 16'h0003;
      i_in_data = 64'hA; tick();
      chk("fill_occ1", {62'd0, o_occupancy}, 64'd1);
      i_in_data = 64'hB; tick();
      chk("fill_occ2", {62'd0, o_occupancy}, 64'd2);
      chk("fill_in_ready0", {63'd0, o_in_ready}, 64'd0);
      i_in_data = 64'hC; tick();
      chk("fill_occ2_hold", {62'd0, o_occupancy}, 64'd2);
      chk("drain_out0", o_out_data, 64'hA);
      i_out_ready = 1'b1; tick();
      chk("drain_out1", o_out_data, 64'hB);
      chk("drain_in_ready1", {63'd0, o_in_ready}, 64'd1);
      tick();
      chk("drain_out2", o_out_data, 64'hC);
      chk("drain_occ1", {62'd0, o_occupancy}, 64'd1);
      i_in_valid = 1'b0; tick();
      chk("drain_empty", {63'd0, o_out_valid}, 64'd0);
      chk("fill_stall", {48'd0, o_stall_cnt}, 64'd2);

      // Streaming: one in, one out per cycle.
      i_in_valid = 1'b1; i_out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         i_in_data = 64'h100 + 64'(k);
         tick();
         chk("stream_data", o_out_data, 64'h100 + 64'(k));
         chk("stream_occ", {62'd0, o_occupancy}, 64'd1);
      end
      i_in_valid = 1'b0; tick();
      chk("stream_stall", {48'd0, o_stall_cnt}, 64'd2);

      // Bubble masking and output masking when idle.
      i_out_ready = 1'b0; i_in_valid = 1'b1; i_in_bubble = 1'b1;
      i_in_ctrl = 16'hFFFF; i_in_data = 64'h1234_5678_9ABC_DEF0; tick();
      i_in_valid = 1'b0;
      chk("bubble_ctrl", {48'd0, o_out_ctrl}, 64'hFF3F);
      chk("bubble_data", o_out_data, 64'h1234_5678_9ABC_DEF0);
      tick();
      i_in_bubble = 1'b0; i_out_ready = 1'b1; tick();
      chk("bubble_idle_ctrl", {48'd0, o_out_ctrl}, 64'hFF3F);
      i_in_valid = 1'b1; i_in_data = 64'h77; tick();
      chk("live_ctrl", {48'd0, o_out_ctrl}, 64'hFFFF);
      i_in_valid = 1'b0; tick();
      chk("idle_mask_ctrl", {48'd0, o_out_ctrl}, 64'hFF3F);
      chk("bubble_stall", {48'd0, o_stall_cnt}, 64'd3);

      // Flush at occupancy 2 and at occupancy 1 with a live accept.
      i_out_ready = 1'b0; i_in_valid = 1'b1; i_in_ctrl = 16'h00C5;
      i_in_data = 64'h51; tick();
      i_in_data = 64'h52; tick();
      chk("flush_pre_occ", {62'd0, o_occupancy}, 64'd2);
      i_in_data = 64'h53; i_flush = 1'b1; tick();
      chk("flush2_occ", {62'd0, o_occupancy}, 64'd0);
      i_flush = 1'b0; i_in_data = 64'h54; tick();
      chk("flush_refill", o_out_data, 64'h54);
      i_in_data = 64'h55; i_flush = 1'b1; i_in_bubble = 1'b1; tick();
      chk("flush1_occ", {62'd0, o_occupancy}, 64'd0);
      i_flush = 1'b0; i_in_bubble = 1'b0; i_in_valid = 1'b0; tick();
      chk("flush_stays_empty", {63'd0, o_out_valid}, 64'd0);
      i_in_valid = 1'b1; i_in_data = 64'h60; i_out_ready = 1'b1; tick();
      chk("flush_next_data", o_out_data, 64'h60);
      i_in_valid = 1'b0; tick();
      chk("flush_stall", {48'd0, o_stall_cnt}, 64'd6);

      // Stall counter saturation.
      i_out_ready = 1'b0; i_in_valid = 1'b1; i_in_data = 64'hCAFE; tick();
      i_in_valid = 1'b0;
      repeat (1000) tick();
      chk("stall_1006", {48'd0, o_stall_cnt}, 64'd1006);
      repeat (69000) tick();
      chk("stall_sat", {48'd0, o_stall_cnt}, 64'hFFFF);
      i_out_ready = 1'b1; tick();
      chk("sat_drained", {62'd0, o_occupancy}, 64'd0);
      chk("sat_hold", {48'd0, o_stall_cnt}, 64'hFFFF);
      tick();

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
